diffeq_sequencer: RTL and testbench
===================================

# diffeq_sequencer

Sequencer for the differential-equation solver datapath. It runs the iteration y'' + 3xy' + 3y = 0 (x1 = x+dx; u1 = u − 3x·u·dx − 3y·dx; y1 = y + u·dx) using one shared, externally owned multiplier through a request/acknowledge handshake. It sits between the operand-load front end, which supplies x, dx, u, y and a once per run, and the multiplier resource. It returns the final x, y and u with a done pulse.

## Interface
- WIDTH, 16: datapath width. All arithmetic is unsigned modulo 2^WIDTH.
- MAX_ITER, 1024: iteration cap. The run stops with timeout when the cap is reached.
- ITER_W, 16: width of iter_count.

- clk  in  1  clock. Reset is asynchronous, active-high, on signal reset.
- reset  in  1  asynchronous, active-high. Returns the block to IDLE.
- start  in  1  one-cycle run request. Honoured only in IDLE.
- x_in, dx_in, u_in, y_in, a_in  in  WIDTH each  initial operands. Captured on the accepted start.
- mul_req  out  1  multiply request. Held high until acknowledged.
- mul_a, mul_b  out  WIDTH each  multiplier operands. Stable while mul_req is high.
- mul_ack  in  1  product valid this cycle. Ignored when mul_req is low.
- mul_p  in  WIDTH  product (low WIDTH bits). Sampled when mul_req and mul_ack are both high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at run end.
- timeout  out  1  set with done when MAX_ITER stopped the run. Held until the next accepted start.
- x_out, y_out, u_out  out  WIDTH each  current state registers. Final values are valid from done onward.
- iter_count  out  ITER_W  completed iterations. Cleared on start.

## Operation
- States: IDLE, M1, M2, M3, M4, M5, UPDATE, CHECK, DONE.
- IDLE
  - On start: capture the five operands into x, dx, u, y, a; clear iter_count and timeout; go to M1.
  - Without start: stay in IDLE.
- Multiply schedule:
  - M1: t1 = u·dx
  - M2: t2 = 3·x
  - M3: t3 = 3·y
  - M4: t4 = t2·t1
  - M5: t5 = t3·dx
- Multiply handshake:
  - In each Mk state, mul_req is high and mul_a/mul_b carry that state's operands.
  - On mul_ack, store the product in tk and advance one state.
  - Without mul_ack, hold the state, the request and the operands.
- UPDATE: in one cycle, u ← u − t4 − t5, y ← y + t1, x ← x + dx, iter_count ← iter_count + 1.
- CHECK
  - If x < a (unsigned) and iter_count < MAX_ITER: go to M1.
  - If x < a and iter_count == MAX_ITER: set timeout, go to DONE.
  - Otherwise (x ≥ a): go to DONE.
  - The loop is do-while: at least one iteration always runs, even if x_in ≥ a_in.
- DONE: done = 1 for one cycle, then IDLE. x_out, y_out and u_out hold until the next start.
- start outside IDLE is ignored. It is not queued.
- Wrap-around (x + dx overflow, u underflow) is not flagged. The compare uses the wrapped x.
- Reset values: state IDLE. mul_req, busy, done and timeout are 0. mul_a, mul_b, x_out, y_out, u_out, iter_count and all internal registers are 0.
- Reset mid-run:
  - mul_req drops asynchronously. The multiplier owner must discard the in-flight request.
  - No done is generated.

## Timing
- An accepted start at edge N puts the block in M1 after edge N; mul_req rises in that cycle.
- Mk with mul_ack in the same cycle costs 1 cycle. With mul_ack L cycles after the request it costs L+1 cycles.
- Iteration length = 7 + Σ(multiply wait cycles). The minimum is 7 cycles: M1–M5, UPDATE, CHECK.
- done rises in the cycle after the CHECK cycle that ends the run.
- With zero-wait multiplies, a single-iteration run has done 8 cycles after the start cycle.
- busy drops in the cycle after done.
- All outputs are registered except mul_a and mul_b, which are a mux of state and registers.

## Test plan
- Single iteration, zero-wait multiplier:
  - Stimulus: x=0, dx=1, u=1, y=1, a=1.
  - Response: done 8 cycles after start; x_out=1, y_out=2, u_out=65534 (WIDTH=16); iter_count=1; timeout=0.
- Multi-iteration:
  - Stimulus: x=0, dx=1, u=0, y=0, a=3.
  - Response: iter_count=3, x_out=3, y_out=0, u_out=0; exactly 5 mul_ack handshakes per iteration.
- Stalled multiplier:
  - Stimulus: mul_ack delayed 4 cycles on every request.
  - Response: mul_req/mul_a/mul_b held stable while waiting; results match the zero-wait run; single-iteration latency 8+5·4=28 cycles.
- Timeout:
  - Stimulus: dx=0, x=0, a=5, MAX_ITER=8.
  - Response: done with timeout=1 and iter_count=8.
- Start while busy:
  - Stimulus: a second start with different operands pulsed during M3.
  - Response: ignored; results come from the first operands; only one done pulse.
- Reset mid-run:
  - Stimulus: reset asserted in M4 while mul_req is high.
  - Response: mul_req=0, busy=0, all outputs 0 immediately; no done pulse; a fresh start afterwards runs normally.

Source files
------------

// File: rtl/diffeq_sequencer.sv
// Sequencer for the y'' + 3xy' + 3y = 0 iteration.
// Shares one external multiplier through a req/ack handshake.
module diffeq_sequencer #(
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 1024,
  parameter int ITER_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  x_in,
  input  logic [WIDTH-1:0]  dx_in,
  input  logic [WIDTH-1:0]  u_in,
  input  logic [WIDTH-1:0]  y_in,
  input  logic [WIDTH-1:0]  a_in,
  output logic              mul_req,
  output logic [WIDTH-1:0]  mul_a,
  output logic [WIDTH-1:0]  mul_b,
  input  logic              mul_ack,
  input  logic [WIDTH-1:0]  mul_p,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [WIDTH-1:0]  x_out,
  output logic [WIDTH-1:0]  y_out,
  output logic [WIDTH-1:0]  u_out,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_M1,
    S_M2,
    S_M3,
    S_M4,
    S_M5,
    S_UPDATE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [ITER_W-1:0] MaxIt = ITER_W'(MAX_ITER);
  localparam logic [WIDTH-1:0]  Three = WIDTH'(3);

  state_e state_q, state_d;

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] dx_q, dx_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] t1_q, t1_d;
  logic [WIDTH-1:0] t2_q, t2_d;
  logic [WIDTH-1:0] t3_q, t3_d;
  logic [WIDTH-1:0] t4_q, t4_d;
  logic [WIDTH-1:0] t5_q, t5_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic timeout_q, timeout_d;
  logic req_q, req_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    dx_d      = dx_q;
    u_d       = u_q;
    y_d       = y_q;
    a_d       = a_q;
    t1_d      = t1_q;
    t2_d      = t2_q;
    t3_d      = t3_q;
    t4_d      = t4_q;
    t5_d      = t5_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d       = x_in;
          dx_d      = dx_in;
          u_d       = u_in;
          y_d       = y_in;
          a_d       = a_in;
          iter_d    = '0;
          timeout_d = 1'b0;
          state_d   = S_M1;
        end
      end
      S_M1: if (mul_ack) begin
        t1_d    = mul_p;
        state_d = S_M2;
      end
      S_M2: if (mul_ack) begin
        t2_d    = mul_p;
        state_d = S_M3;
      end
      S_M3: if (mul_ack) begin
        t3_d    = mul_p;
        state_d = S_M4;
      end
      S_M4: if (mul_ack) begin
        t4_d    = mul_p;
        state_d = S_M5;
      end
      S_M5: if (mul_ack) begin
        t5_d    = mul_p;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        u_d     = u_q - t4_q - t5_q;
        y_d     = y_q + t1_q;
        x_d     = x_q + dx_q;
        iter_d  = iter_q + 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (x_q < a_q) begin
          if (iter_q >= MaxIt) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_M1;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state
  always_comb begin
    req_d  = (state_d inside {S_M1, S_M2, S_M3, S_M4, S_M5});
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      S_M1: begin
        mul_a = u_q;
        mul_b = dx_q;
      end
      S_M2: begin
        mul_a = Three;
        mul_b = x_q;
      end
      S_M3: begin
        mul_a = Three;
        mul_b = y_q;
      end
      S_M4: begin
        mul_a = t2_q;
        mul_b = t1_q;
      end
      S_M5: begin
        mul_a = t3_q;
        mul_b = dx_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      dx_q      <= '0;
      u_q       <= '0;
      y_q       <= '0;
      a_q       <= '0;
      t1_q      <= '0;
      t2_q      <= '0;
      t3_q      <= '0;
      t4_q      <= '0;
      t5_q      <= '0;
      iter_q    <= '0;
      timeout_q <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      dx_q      <= dx_d;
      u_q       <= u_d;
      y_q       <= y_d;
      a_q       <= a_d;
      t1_q      <= t1_d;
      t2_q      <= t2_d;
      t3_q      <= t3_d;
      t4_q      <= t4_d;
      t5_q      <= t5_d;
      iter_q    <= iter_d;
      timeout_q <= timeout_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mul_req    = req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign u_out      = u_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_diffeq_sequencer.sv
// Scoreboard bench for diffeq_sequencer.
// Directed runs with hand-computed results and a delayable multiplier.
module tb_diffeq_sequencer;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  x_in = '0, dx_in = '0, u_in = '0, y_in = '0, a_in = '0;
  logic          mul_req;
  logic [W-1:0]  mul_a, mul_b;
  logic          mul_ack = 1'b0;
  logic [W-1:0]  mul_p = '0;
  logic          busy, done, timeout;
  logic [W-1:0]  x_out, y_out, u_out;
  logic [15:0]   iter_count;

  diffeq_sequencer #(
    .WIDTH(W),
    .MAX_ITER(8),
    .ITER_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .x_in(x_in),
    .dx_in(dx_in),
    .u_in(u_in),
    .y_in(y_in),
    .a_in(a_in),
    .mul_req(mul_req),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_ack(mul_ack),
    .mul_p(mul_p),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .x_out(x_out),
    .y_out(y_out),
    .u_out(u_out),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] u;
    int           it;
    logic         to;
    int           lat;
    int           start_cyc;
    int           start_acks;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_total = 0;
  int mul_delay = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // External multiplier: acks after mul_delay waiting cycles
  int wcnt = 0;
  always @(posedge clk or posedge reset) begin
    logic [31:0] prod;
    #1;
    if (reset || !mul_req) begin
      mul_ack = 1'b0;
      wcnt = 0;
    end else if (wcnt >= mul_delay) begin
      prod = mul_a * mul_b;
      mul_p = prod[W-1:0];
      mul_ack = 1'b1;
      wcnt = 0;
    end else begin
      mul_ack = 1'b0;
      wcnt++;
    end
  end

  // Monitor
  logic         p_req = 1'b0, p_ack = 1'b0, p_done = 1'b0;
  logic [W-1:0] p_a = '0, p_b = '0;
  always @(negedge clk) begin
    exp_t e;
    if (mul_req && mul_ack) ack_total++;
    if (!reset && mul_req && p_req && !p_ack) begin
      chk("stall_mul_a", mul_a, p_a);
      chk("stall_mul_b", mul_b, p_b);
    end
    if (p_done) chk("busy_after_done", busy, 0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("x_out", x_out, e.x);
        chk("y_out", y_out, e.y);
        chk("u_out", u_out, e.u);
        chk("iter_count", iter_count, e.it);
        chk("timeout", timeout, e.to);
        chk("latency", cyc - e.start_cyc, e.lat);
        chk("mul_acks", ack_total - e.start_acks, 5 * e.it);
        chk("busy_at_done", busy, 1);
      end
    end
    p_req  = mul_req;
    p_ack  = mul_ack;
    p_a    = mul_a;
    p_b    = mul_b;
    p_done = done;
  end

  task automatic drive(input logic [W-1:0] x, dx, u, y, a);
    x_in  = x;
    dx_in = dx;
    u_in  = u;
    y_in  = y;
    a_in  = a;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 1000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (i == 1000) chk({name, "_idle_wait"}, 0, 1);
  endtask

  task automatic run(input string name,
                     input logic [W-1:0] x, dx, u, y, a,
                     input logic [W-1:0] ex, ey, eu,
                     input int eit, input logic eto, input int elat,
                     input int dly, input bit inject);
    exp_t e;
    mul_delay = dly;
    @(negedge clk);
    drive(x, dx, u, y, a);
    start = 1'b1;
    e.x = ex;
    e.y = ey;
    e.u = eu;
    e.it = eit;
    e.to = eto;
    e.lat = elat;
    e.start_cyc = cyc;
    e.start_acks = ack_total;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk({name, "_iter_clr"}, iter_count, 0);
    chk({name, "_to_clr"}, timeout, 0);
    if (inject) begin
      @(negedge clk);
      @(negedge clk);
      drive(16'd0, 16'd1, 16'd1, 16'd1, 16'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req", mul_req, 0);
    chk("rst_outs", {done, timeout, x_out, y_out, u_out, iter_count}, 0);
    chk("rst_mul_ab", {mul_a, mul_b}, 0);
    reset = 1'b0;

    run("single", 0, 1, 1, 1, 1, 1, 2, 65534, 1, 0, 8, 0, 0);
    run("multi", 0, 1, 0, 0, 3, 3, 0, 0, 3, 0, 22, 0, 0);
    run("stall", 0, 1, 1, 1, 1, 1, 2, 65534, 1, 0, 28, 4, 0);
    run("arith", 2, 1, 5, 7, 3, 3, 12, 65490, 1, 0, 8, 0, 0);
    run("dowhile", 5, 1, 0, 0, 2, 6, 0, 0, 1, 0, 8, 0, 0);
    run("tmo", 0, 0, 0, 0, 5, 0, 0, 0, 8, 1, 57, 0, 0);
    repeat (3) @(negedge clk);
    chk("tmo_hold", timeout, 1);
    run("busy_start", 2, 1, 5, 7, 3, 3, 12, 65490, 1, 0, 8, 0, 1);

    // Reset during M4 while the request is pending
    mul_delay = 4;
    @(negedge clk);
    drive(16'd2, 16'd1, 16'd5, 16'd7, 16'd3);
    start = 1'b1;
    begin
      int a0;
      a0 = ack_total;
      @(negedge clk);
      start = 1'b0;
      for (i = 0; i < 100; i++) begin
        if (ack_total - a0 == 3 && mul_req && !mul_ack) break;
        @(negedge clk);
      end
      chk("rst_reach_m4", i < 100, 1);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", mul_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outs", {done, timeout, x_out, y_out, u_out, iter_count}, 0);
    chk("mid_rst_mul_ab", {mul_a, mul_b}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run("after_rst", 0, 1, 1, 1, 1, 1, 2, 65534, 1, 0, 8, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
